// File: rtl/huffman_frame_ctrl_if.sv
// Bundle of upstream pixel, encoder and downstream result signals for huffman_frame_ctrl.
// The slave modport is the controller's view; master is the surrounding environment.
interface huffman_frame_ctrl_if;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_data;
    logic        pix_last;
    logic        enc_rst;
    logic        gray_valid;
    logic [7:0]  gray_data;
    logic        enc_cnt_valid;
    logic [47:0] enc_cnt;
    logic        enc_code_valid;
    logic [47:0] enc_hc;
    logic [47:0] enc_m;
    logic        res_valid;
    logic        res_ready;
    logic [47:0] res_cnt;
    logic [47:0] res_hc;
    logic [47:0] res_m;
    logic [7:0]  res_len;
    logic        res_trunc;
    logic        res_timeout;
    logic [15:0] frame_cnt;

    modport slave (
        input  pix_valid, pix_data, pix_last, enc_cnt_valid, enc_cnt,
               enc_code_valid, enc_hc, enc_m, res_ready,
        output pix_ready, enc_rst, gray_valid, gray_data, res_valid, res_cnt,
               res_hc, res_m, res_len, res_trunc, res_timeout, frame_cnt
    );

    modport master (
        output pix_valid, pix_data, pix_last, enc_cnt_valid, enc_cnt,
               enc_code_valid, enc_hc, enc_m, res_ready,
        input  pix_ready, enc_rst, gray_valid, gray_data, res_valid, res_cnt,
               res_hc, res_m, res_len, res_trunc, res_timeout, frame_cnt
    );
endinterface

// File: rtl/huffman_frame_ctrl.sv
// Frame sequencer for the 6-symbol Huffman encoder: buffers a frame, replays it as one
// gap-free burst, collects counts/codes, and re-resets the encoder between frames.
module huffman_frame_ctrl #(
    parameter int FRAME_DEPTH = 200,
    parameter int ADDR_W      = 8,
    parameter int RST_CYCLES  = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    huffman_frame_ctrl_if.slave   bus
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam int RC_W   = $clog2(RST_CYCLES + 1);

    localparam logic [2:0] S_ENC_RST   = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_STREAM    = 3'd2;
    localparam logic [2:0] S_WAIT_CNT  = 3'd3;
    localparam logic [2:0] S_WAIT_CODE = 3'd4;
    localparam logic [2:0] S_OUT       = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [RC_W-1:0]   rc_q, rc_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              trunc_q, trunc_d;
    logic              timeout_q, timeout_d;
    logic              gray_valid_q, gray_valid_d;
    logic [7:0]        gray_data_q, gray_data_d;
    logic [47:0]       cnt_q, cnt_d;
    logic [47:0]       hc_q, hc_d;
    logic [47:0]       m_q, m_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              beat;

    // Sized to the full address space so every pointer value is a legal index.
    logic [7:0]        mem [2**ADDR_W];

    assign beat = bus.pix_valid && (state_q == S_LOAD);

    always_comb begin
        state_d      = state_q;
        rc_d         = rc_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wait_d       = wait_q;
        trunc_d      = trunc_q;
        timeout_d    = timeout_q;
        cnt_d        = cnt_q;
        hc_d         = hc_q;
        m_d          = m_q;
        frame_cnt_d  = frame_cnt_q;
        gray_valid_d = 1'b0;
        gray_data_d  = 8'd0;
        case (state_q)
            S_ENC_RST: begin
                count_d   = '0;
                rd_ptr_d  = '0;
                wait_d    = '0;
                trunc_d   = 1'b0;
                timeout_d = 1'b0;
                cnt_d     = '0;
                hc_d      = '0;
                m_d       = '0;
                if (rc_q == RC_W'(RST_CYCLES - 1)) begin
                    rc_d    = '0;
                    state_d = S_LOAD;
                end else begin
                    rc_d = rc_q + RC_W'(1);
                end
            end
            S_LOAD: begin
                if (beat) begin
                    count_d = count_q + ADDR_W'(1);
                    if (bus.pix_last) begin
                        state_d = S_STREAM;
                    end else if (count_q == ADDR_W'(FRAME_DEPTH - 1)) begin
                        trunc_d = 1'b1;
                        state_d = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                // Read issued here lands on gray_data one cycle later, so the burst has no bubbles.
                if (rd_ptr_q != count_q) begin
                    gray_valid_d = 1'b1;
                    gray_data_d  = mem[rd_ptr_q];
                    rd_ptr_d     = rd_ptr_q + ADDR_W'(1);
                end else begin
                    wait_d  = '0;
                    state_d = S_WAIT_CNT;
                end
            end
            S_WAIT_CNT: begin
                if (bus.enc_cnt_valid) begin
                    cnt_d   = bus.enc_cnt;
                    wait_d  = '0;
                    state_d = S_WAIT_CODE;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_OUT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WAIT_CODE: begin
                if (bus.enc_code_valid) begin
                    hc_d    = bus.enc_hc;
                    m_d     = bus.enc_m;
                    state_d = S_OUT;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_OUT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_OUT: begin
                if (bus.res_ready) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = S_ENC_RST;
                end
            end
            default: state_d = S_ENC_RST;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_ENC_RST;
            rc_q         <= '0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wait_q       <= '0;
            trunc_q      <= 1'b0;
            timeout_q    <= 1'b0;
            gray_valid_q <= 1'b0;
            gray_data_q  <= 8'd0;
            cnt_q        <= '0;
            hc_q         <= '0;
            m_q          <= '0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            rc_q         <= rc_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wait_q       <= wait_d;
            trunc_q      <= trunc_d;
            timeout_q    <= timeout_d;
            gray_valid_q <= gray_valid_d;
            gray_data_q  <= gray_data_d;
            cnt_q        <= cnt_d;
            hc_q         <= hc_d;
            m_q          <= m_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (beat) begin
            mem[count_q] <= bus.pix_data;
        end
    end

    assign bus.pix_ready   = (state_q == S_LOAD);
    assign bus.enc_rst     = (state_q == S_ENC_RST);
    assign bus.gray_valid  = gray_valid_q;
    assign bus.gray_data   = gray_data_q;
    assign bus.res_valid   = (state_q == S_OUT);
    assign bus.res_cnt     = cnt_q;
    assign bus.res_hc      = hc_q;
    assign bus.res_m       = m_q;
    assign bus.res_len     = 8'(count_q);
    assign bus.res_trunc   = trunc_q;
    assign bus.res_timeout = timeout_q;
    assign bus.frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_huffman_frame_ctrl.sv
// Directed bench: two controller instances (default sizing, and depth 8 / timeout 16)
// behind a shared stimulus mux, with a small encoder stub answering each burst.
module tb_huffman_frame_ctrl;
    localparam logic [47:0] STUB_HC = 48'h0F0E0D0C0B0A;
    localparam logic [47:0] STUB_M  = 48'h070703030101;

    typedef struct packed {
        int          n;
        logic [127:0] px;
        bit          last;
        bit          early;
        int          hold;
        logic [47:0] cnt;
        bit          tmo;
        int          len;
        bit          trunc;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sel = 1'b0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_data = 8'd0;
    logic        pix_last = 1'b0;
    logic        res_ready = 1'b0;
    logic [47:0] stub_cnt = 48'd0;
    logic        stub_no_code = 1'b0;
    logic        st_seen = 1'b0;
    logic        st_done = 1'b0;
    logic        st_cnt_valid = 1'b0;
    logic        st_code_valid = 1'b0;

    logic        m_pix_ready, m_enc_rst, m_gv, m_rv, m_trunc, m_tmo;
    logic [7:0]  m_gd, m_len;
    logic [47:0] m_cnt, m_hc, m_m;
    logic [15:0] m_fc;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  gbuf [256];
    vec_t        va [4];
    vec_t        vb [3];
    vec_t        vr;

    always #5 clk = ~clk;

    huffman_frame_ctrl_if ifa ();
    huffman_frame_ctrl_if ifb ();

    assign ifa.pix_valid      = pix_valid & ~sel;
    assign ifb.pix_valid      = pix_valid & sel;
    assign ifa.pix_data       = pix_data;
    assign ifb.pix_data       = pix_data;
    assign ifa.pix_last       = pix_last;
    assign ifb.pix_last       = pix_last;
    assign ifa.enc_cnt_valid  = st_cnt_valid & ~sel;
    assign ifb.enc_cnt_valid  = st_cnt_valid & sel;
    assign ifa.enc_code_valid = st_code_valid & ~sel;
    assign ifb.enc_code_valid = st_code_valid & sel;
    assign ifa.enc_cnt        = stub_cnt;
    assign ifb.enc_cnt        = stub_cnt;
    assign ifa.enc_hc         = STUB_HC;
    assign ifb.enc_hc         = STUB_HC;
    assign ifa.enc_m          = STUB_M;
    assign ifb.enc_m          = STUB_M;
    assign ifa.res_ready      = res_ready;
    assign ifb.res_ready      = res_ready;

    huffman_frame_ctrl dut_a (.clk(clk), .reset(reset), .bus(ifa));
    huffman_frame_ctrl #(.FRAME_DEPTH(8), .ADDR_W(8), .RST_CYCLES(2), .TIMEOUT(16))
        dut_b (.clk(clk), .reset(reset), .bus(ifb));

    always_comb begin
        m_pix_ready = sel ? ifb.pix_ready   : ifa.pix_ready;
        m_enc_rst   = sel ? ifb.enc_rst     : ifa.enc_rst;
        m_gv        = sel ? ifb.gray_valid  : ifa.gray_valid;
        m_gd        = sel ? ifb.gray_data   : ifa.gray_data;
        m_rv        = sel ? ifb.res_valid   : ifa.res_valid;
        m_cnt       = sel ? ifb.res_cnt     : ifa.res_cnt;
        m_hc        = sel ? ifb.res_hc      : ifa.res_hc;
        m_m         = sel ? ifb.res_m       : ifa.res_m;
        m_len       = sel ? ifb.res_len     : ifa.res_len;
        m_trunc     = sel ? ifb.res_trunc   : ifa.res_trunc;
        m_tmo       = sel ? ifb.res_timeout : ifa.res_timeout;
        m_fc        = sel ? ifb.frame_cnt   : ifa.frame_cnt;
    end

    // Encoder stub: one-cycle CNT_valid after the burst ends, then a sticky code_valid.
    always @(posedge clk) begin
        if (m_enc_rst) begin
            st_seen       <= 1'b0;
            st_done       <= 1'b0;
            st_cnt_valid  <= 1'b0;
            st_code_valid <= 1'b0;
        end else begin
            if (m_gv) st_seen <= 1'b1;
            if (st_seen && !m_gv && !st_done) begin
                st_cnt_valid <= 1'b1;
                st_done      <= 1'b1;
            end else begin
                st_cnt_valid <= 1'b0;
            end
            if (st_cnt_valid && !stub_no_code) st_code_valid <= 1'b1;
        end
    end

    function automatic logic [127:0] pix(input logic [7:0] p0, p1, p2, p3, p4, p5,
                                         input logic [7:0] p6, p7, p8, p9, p10, p11);
        return {32'h0, p11, p10, p9, p8, p7, p6, p5, p4, p3, p2, p1, p0};
    endfunction

    function automatic vec_t mk(input int n, input logic [127:0] px, input bit last,
                                input bit early, input int hold, input logic [47:0] cnt,
                                input bit tmo, input int len, input bit trunc, input int lat);
        vec_t v;
        v.n = n; v.px = px; v.last = last; v.early = early; v.hold = hold;
        v.cnt = cnt; v.tmo = tmo; v.len = len; v.trunc = trunc; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input vec_t v);
        int k;
        for (int i = 0; i < v.n; i++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix_data  = v.px[i*8 +: 8];
            pix_last  = v.last && (i == v.n - 1);
            k = 0;
            while (!m_pix_ready && k < 200) begin
                @(negedge clk);
                k++;
            end
            if (k >= 200) chk("pix_ready_wait", 64'(k), 64'd0);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic collect(input int budget, output int ngv, output int nb,
                           output int lat, output bit got);
        bit prev;
        int last_c;
        prev = 1'b0; ngv = 0; nb = 0; lat = -1; got = 1'b0; last_c = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (m_gv) begin
                if (ngv < 256) gbuf[ngv] = m_gd;
                ngv++;
                if (!prev) nb++;
                last_c = c;
            end
            prev = m_gv;
            if (m_rv) begin
                got = 1'b1;
                lat = c - last_c;
                break;
            end
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v, input int exp_fc);
        int ngv, nb, lat, bad, rc;
        bit got;
        stub_cnt     = v.cnt;
        stub_no_code = v.tmo;
        if (v.early) res_ready = 1'b1;
        send(v);
        collect(600, ngv, nb, lat, got);
        chk({tag, " res_valid_seen"}, 64'(got), 64'd1);
        chk({tag, " gv_cycles"}, 64'(ngv), 64'(v.n));
        chk({tag, " gv_bursts"}, 64'(nb), 64'd1);
        for (int i = 0; i < v.n; i++)
            chk($sformatf("%s gray[%0d]", tag, i), 64'(gbuf[i]), 64'(v.px[i*8 +: 8]));
        chk({tag, " flag_latency"}, 64'(lat), 64'(v.lat));
        chk({tag, " res_cnt"}, 64'(m_cnt), 64'(v.cnt));
        chk({tag, " res_hc"}, 64'(m_hc), v.tmo ? 64'd0 : 64'(STUB_HC));
        chk({tag, " res_m"}, 64'(m_m), v.tmo ? 64'd0 : 64'(STUB_M));
        chk({tag, " res_len"}, 64'(m_len), 64'(v.len));
        chk({tag, " res_trunc"}, 64'(m_trunc), 64'(v.trunc));
        chk({tag, " res_timeout"}, 64'(m_tmo), 64'(v.tmo));
        chk({tag, " frame_cnt_in_out"}, 64'(m_fc), 64'(exp_fc - 1));
        if (v.hold > 0) begin
            bad = 0;
            for (int h = 0; h < v.hold; h++) begin
                @(negedge clk);
                if (!m_rv || m_cnt !== v.cnt || m_len !== 8'(v.len) || m_trunc !== v.trunc)
                    bad++;
            end
            chk({tag, " hold_stable"}, 64'(bad), 64'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, " res_valid_drop"}, 64'(m_rv), 64'd0);
        chk({tag, " frame_cnt"}, 64'(m_fc), 64'(exp_fc));
        rc = 0;
        while (m_enc_rst && rc < 10) begin
            rc++;
            @(negedge clk);
        end
        chk({tag, " enc_rst_cycles"}, 64'(rc), 64'd2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        va[0] = mk(10, pix(1,1,2,3,3,3,4,5,6,6,0,0), 1, 0, 20, 48'h020101030102, 0, 10, 0, 4);
        va[1] = mk(1,  pix(3,0,0,0,0,0,0,0,0,0,0,0), 1, 1, 0,  48'h000000010000, 0, 1,  0, 4);
        va[2] = mk(4,  pix(0,7,255,6,0,0,0,0,0,0,0,0), 1, 0, 3, 48'h010000000000, 0, 4,  0, 4);
        va[3] = mk(6,  pix(6,5,4,3,2,1,0,0,0,0,0,0), 1, 0, 0,  48'h010101010101, 0, 6,  0, 4);
        vr    = mk(3,  pix(2,4,2,0,0,0,0,0,0,0,0,0), 1, 0, 0,  48'h000001000200, 0, 3,  0, 4);
        vb[0] = mk(8,  pix(1,2,3,4,5,6,1,2,0,0,0,0), 0, 0, 0,  48'h010101010202, 0, 8,  1, 4);
        vb[1] = mk(4,  pix(3,4,5,6,0,0,0,0,0,0,0,0), 1, 0, 0,  48'h010101010000, 0, 4,  0, 4);
        vb[2] = mk(3,  pix(1,2,3,0,0,0,0,0,0,0,0,0), 1, 0, 0,  48'h000000010101, 1, 3,  0, 19);

        // Values held while reset is asserted.
        @(negedge clk);
        chk("rst enc_rst", 64'(m_enc_rst), 64'd1);
        chk("rst pix_ready", 64'(m_pix_ready), 64'd0);
        chk("rst gray_valid", 64'(m_gv), 64'd0);
        chk("rst gray_data", 64'(m_gd), 64'd0);
        chk("rst res_valid", 64'(m_rv), 64'd0);
        chk("rst res_len", 64'(m_len), 64'd0);
        chk("rst res_cnt", 64'(m_cnt), 64'd0);
        chk("rst frame_cnt", 64'(m_fc), 64'd0);
        reset = 1'b1;

        for (int i = 0; i < 4; i++) run_vec($sformatf("A%0d", i), va[i], i + 1);

        // Reset pulse in the middle of a burst.
        stub_cnt = 48'd0;
        send(mk(8, pix(1,2,3,4,5,6,1,2,0,0,0,0), 1, 0, 0, 48'd0, 0, 8, 0, 4));
        @(negedge clk);
        chk("midrst gv_before", 64'(m_gv), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("midrst gv_async", 64'(m_gv), 64'd0);
        chk("midrst enc_rst_async", 64'(m_enc_rst), 64'd1);
        chk("midrst frame_cnt", 64'(m_fc), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (m_rv || m_gv) bad++;
        end
        chk("midrst no_output", 64'(bad), 64'd0);
        run_vec("R0", vr, 1);

        // Depth-8 / timeout-16 instance.
        @(negedge clk);
        sel = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) run_vec($sformatf("B%0d", i), vb[i], i + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/huffman_frame_ctrl.md
Name: huffman_frame_ctrl

Overview:
- Frame sequencer in front of the 6-symbol Huffman encoder (gray values 1..6, 8-bit counts, 8-bit HCn/Mn outputs).
- Accepts pixels from upstream on a valid/ready handshake and buffers one whole frame.
- Replays the frame to the encoder as one gap-free gray_valid burst, then collects counts and codes and hands them downstream on a valid/ready handshake.
- Re-resets the encoder between frames, because the encoder has no restart path.

Parameters:
FRAME_DEPTH, 200, maximum pixels per frame; legal range 1..255 so encoder 8-bit counters cannot wrap
ADDR_W, 8, buffer address and pixel-count width
RST_CYCLES, 2, cycles enc_rst is held high before each frame
TIMEOUT, 255, maximum cycles waited for each encoder flag

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
pix_valid  in  1  upstream pixel valid
pix_ready  out  1  upstream ready
pix_data  in  8  gray value
pix_last  in  1  final pixel of frame
enc_rst  out  1  active-high reset to encoder
gray_valid  out  1  to encoder
gray_data  out  8  to encoder
enc_cnt_valid  in  1  encoder CNT_valid
enc_cnt  in  48  {CNT6..CNT1}
enc_code_valid  in  1  encoder code_valid
enc_hc  in  48  {HC6..HC1}
enc_m  in  48  {M6..M1}
res_valid  out  1  result valid
res_ready  in  1  downstream ready
res_cnt  out  48  captured counts
res_hc  out  48  captured codes
res_m  out  48  captured masks
res_len  out  8  pixels in frame
res_trunc  out  1  frame cut at FRAME_DEPTH
res_timeout  out  1  encoder flag missed
frame_cnt  out  16  completed frames, wraps 0xFFFF->0

Behaviour:
- Reset (reset=0, async) puts state in ENC_RST. Output values while reset=0:
  - enc_rst=1.
  - pix_ready, gray_valid, res_valid=0.
  - All data outputs, res_* and frame_cnt=0.
  - Buffer contents are don't-care.
- States: ENC_RST -> LOAD -> STREAM -> WAIT_CNT -> WAIT_CODE -> OUT -> ENC_RST.
- ENC_RST:
  - enc_rst=1 for exactly RST_CYCLES cycles, then LOAD.
  - Clears pixel counter, wait counter and trunc/timeout flags.
- LOAD:
  - pix_ready=1 only in LOAD.
  - Each pix_valid&pix_ready beat writes pix_data to buffer[count] and increments count.
  - A beat with pix_last -> STREAM.
  - The beat that makes count==FRAME_DEPTH without pix_last -> STREAM with trunc=1. Remaining upstream pixels form the next frame.
  - pix_data outside 1..6 is stored and streamed unchanged; the encoder ignores it.
- STREAM:
  - Synchronous buffer read. gray_valid=1 for exactly count consecutive cycles, starting the cycle after STREAM entry, with gray_data=buffer[0..count-1] in order and no bubbles.
  - Then gray_valid=0 and go to WAIT_CNT. gray_data returns to 0.
- WAIT_CNT:
  - First cycle enc_cnt_valid=1: capture enc_cnt into res_cnt and go to WAIT_CODE.
- WAIT_CODE:
  - First cycle enc_code_valid=1 (level, sticky in encoder): capture enc_hc and enc_m, go to OUT.
- Timeout:
  - Wait counter restarts on entry to each WAIT state.
  - Reaching TIMEOUT without the flag: set timeout=1, leave uncaptured fields 0, go to OUT.
- OUT:
  - res_valid=1 with res_len=count, res_trunc, res_timeout; all res_* stable while res_valid=1 and res_ready=0.
  - On res_valid&res_ready: res_valid=0 next cycle, frame_cnt+1, go to ENC_RST.
  - res_ready high on OUT entry completes the handshake in the first OUT cycle.
- Stray flags: enc_cnt_valid or enc_code_valid outside its WAIT state is ignored.
- Reset mid-frame: the frame is discarded, nothing is output, and enc_rst goes high immediately (async).
- Latency for an N-pixel frame with immediate encoder flags: first res_valid no earlier than N+4 cycles after the last LOAD beat.

Test Plan:
- Frame {1,1,2,3,3,3,4,5,6,6} with pix_last on the 10th beat and stub encoder returning CNT=2,1,3,1,1,2 -> gray_valid high exactly 10 consecutive cycles with the same data order; res_cnt equals stub value; res_len=10; res_trunc=0; frame_cnt=1.
- res_ready held low 20 cycles in OUT -> res_valid stays 1 and res_* unchanged; one ready cycle -> res_valid drops next cycle; enc_rst high exactly 2 cycles after.
- FRAME_DEPTH=8, 12 pixels with last on 12th -> frame A: res_len=8, res_trunc=1; frame B: res_len=4, res_trunc=0.
- Stub never raises enc_code_valid, TIMEOUT=16 -> res_timeout=1 after 16 cycles in WAIT_CODE; res_hc=0 and res_m=0; res_cnt keeps captured value.
- reset low mid-STREAM for 1 cycle -> gray_valid=0 and enc_rst=1 immediately; no res_valid; next frame processes normally with frame_cnt=1.
- Single-pixel frame value 3 -> exactly one gray_valid cycle with gray_data=3, res_len=1.
